// File: rtl/io_port.sv
// Memory-mapped general-purpose I/O port: direction, data and edge-interrupt registers,
// with a tick-clocked input synchroniser and an optional per-pin debounce filter.
module io_port #(
    parameter int          NUM_PINS        = 8,
    parameter logic [23:0] BASE_ADDR       = 24'h002060,
    parameter int          DEBOUNCE_CYCLES = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_ce,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    input  logic [NUM_PINS-1:0] pin_in,
    output logic [NUM_PINS-1:0] pin_out,
    output logic [NUM_PINS-1:0] pin_oe,
    output logic                irq
);

    localparam logic [23:0] ADDR_DIR  = BASE_ADDR;
    localparam logic [23:0] ADDR_DATA = BASE_ADDR + 24'd1;
    localparam logic [23:0] ADDR_EN   = BASE_ADDR + 24'd2;
    localparam logic [23:0] ADDR_EDGE = BASE_ADDR + 24'd3;
    localparam logic [23:0] ADDR_PEND = BASE_ADDR + 24'd4;

    logic [NUM_PINS-1:0] dir_reg, data_reg, irq_en_reg, irq_edge_reg, pend_reg;
    logic [NUM_PINS-1:0] dir_next, data_next, irq_en_next, irq_edge_next, pend_next;
    logic [NUM_PINS-1:0] sync1_reg, sync2_reg, prev_reg, filtered;
    logic [NUM_PINS-1:0] pin_oe_reg, pin_out_reg;
    logic [NUM_PINS-1:0] wr_data, pend_clr, edge_rise, edge_fall, edge_hit, rd_vec;
    logic                irq_reg;
    logic                sel_dir, sel_data, sel_en, sel_edge, sel_pend;

    assign sel_dir  = (bus_address_in == ADDR_DIR);
    assign sel_data = (bus_address_in == ADDR_DATA);
    assign sel_en   = (bus_address_in == ADDR_EN);
    assign sel_edge = (bus_address_in == ADDR_EDGE);
    assign sel_pend = (bus_address_in == ADDR_PEND);

    assign wr_data = bus_data_in[NUM_PINS-1:0];

    assign dir_next      = (bus_write && sel_dir)  ? wr_data : dir_reg;
    assign data_next     = (bus_write && sel_data) ? wr_data : data_reg;
    assign irq_en_next   = (bus_write && sel_en)   ? wr_data : irq_en_reg;
    assign irq_edge_next = (bus_write && sel_edge) ? wr_data : irq_edge_reg;

    assign edge_rise = filtered & ~prev_reg;
    assign edge_fall = ~filtered & prev_reg;
    assign edge_hit  = irq_en_reg & ((irq_edge_reg & edge_rise) | (~irq_edge_reg & edge_fall));
    assign pend_clr  = (bus_write && sel_pend) ? wr_data : '0;
    // A new edge wins over a simultaneous write-1-to-clear of the same bit.
    assign pend_next = (pend_reg & ~pend_clr) | edge_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_reg      <= '0;
            data_reg     <= '0;
            irq_en_reg   <= '0;
            irq_edge_reg <= '0;
            pend_reg     <= '0;
            pin_oe_reg   <= '0;
            pin_out_reg  <= '0;
            irq_reg      <= 1'b0;
            sync1_reg    <= '1;
            sync2_reg    <= '1;
            prev_reg     <= '1;
        end else if (clk_ce) begin
            dir_reg      <= dir_next;
            data_reg     <= data_next;
            irq_en_reg   <= irq_en_next;
            irq_edge_reg <= irq_edge_next;
            pend_reg     <= pend_next;
            pin_oe_reg   <= dir_next;
            pin_out_reg  <= data_next & dir_next;
            irq_reg      <= |(pend_reg & irq_en_reg);
            sync1_reg    <= pin_in;
            sync2_reg    <= sync1_reg;
            prev_reg     <= filtered;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign filtered = sync2_reg;
        end else begin : g_debounce
            localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
            genvar gi;
            for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
                logic [7:0] cnt_reg;
                logic       filt_reg;
                // The counter only runs while the synchronised level disagrees with the accepted one.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        cnt_reg  <= '0;
                        filt_reg <= 1'b1;
                    end else if (clk_ce) begin
                        if (sync2_reg[gi] == filt_reg) begin
                            cnt_reg <= '0;
                        end else if (cnt_reg == DB_LAST) begin
                            filt_reg <= sync2_reg[gi];
                            cnt_reg  <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                        end
                    end
                end
                assign filtered[gi] = filt_reg;
            end
        end
    endgenerate

    always_comb begin
        rd_vec = '0;
        if (bus_read) begin
            if (sel_dir)       rd_vec = dir_reg;
            else if (sel_data) rd_vec = (data_reg & dir_reg) | (filtered & ~dir_reg);
            else if (sel_en)   rd_vec = irq_en_reg;
            else if (sel_edge) rd_vec = irq_edge_reg;
            else if (sel_pend) rd_vec = pend_reg;
        end
    end

    assign bus_data_out = 8'(rd_vec);
    assign pin_oe       = pin_oe_reg;
    assign pin_out      = pin_out_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: two instances (8 pins unfiltered, 3 pins with 4-tick debounce) on
// separate addresses, checked every cycle against a register-level model plus directed literals.
module tb_io_port;

    localparam logic [23:0] BASE0 = 24'h002060;
    localparam logic [23:0] BASE1 = 24'h003000;

    logic        clk, reset, clk_ce, bus_write, bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  rd0, rd1;
    logic [7:0]  pin_in0, pin_out0, pin_oe0;
    logic [2:0]  pin_in1, pin_out1, pin_oe1;
    logic        irq0, irq1;

    int n_tests = 0;
    int n_fail  = 0;

    io_port u0 (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write), .bus_read(bus_read),
        .bus_address_in(bus_address_in), .bus_data_in(bus_data_in), .bus_data_out(rd0),
        .pin_in(pin_in0), .pin_out(pin_out0), .pin_oe(pin_oe0), .irq(irq0)
    );

    io_port #(.NUM_PINS(3), .BASE_ADDR(BASE1), .DEBOUNCE_CYCLES(4)) u1 (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write), .bus_read(bus_read),
        .bus_address_in(bus_address_in), .bus_data_in(bus_data_in), .bus_data_out(rd1),
        .pin_in(pin_in1), .pin_out(pin_out1), .pin_oe(pin_oe1), .irq(irq1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] m_dir[2], m_data[2], m_en[2], m_edge[2], m_pend[2];
    logic [7:0] m_s1[2], m_s2[2], m_flt[2], m_prev[2];
    logic       m_irq[2];
    int         m_run[2][8];

    function automatic logic [7:0] pin_mask(input int np);
        return 8'((1 << np) - 1);
    endfunction

    task automatic model_reset(input int i, input int np);
        m_dir[i] = 0; m_data[i] = 0; m_en[i] = 0; m_edge[i] = 0; m_pend[i] = 0; m_irq[i] = 0;
        m_s1[i] = pin_mask(np); m_s2[i] = pin_mask(np);
        m_flt[i] = pin_mask(np); m_prev[i] = pin_mask(np);
        for (int b = 0; b < 8; b++) m_run[i][b] = 0;
    endtask

    task automatic model_step(input int i, input logic [7:0] pins, input int np,
                              input int db, input logic [23:0] base);
        logic [7:0] mask, d, rise, fall, hit, clr;
        mask = pin_mask(np);
        d    = bus_data_in & mask;
        rise = m_flt[i] & ~m_prev[i];
        fall = ~m_flt[i] & m_prev[i];
        hit  = m_en[i] & ((m_edge[i] & rise) | (~m_edge[i] & fall));
        clr  = (bus_write && bus_address_in == base + 24'd4) ? d : 8'h00;
        m_irq[i]  = |(m_pend[i] & m_en[i]);
        m_pend[i] = (m_pend[i] & ~clr) | hit;
        m_prev[i] = m_flt[i];
        if (db > 0) begin
            // accept a new level after it has disagreed with the accepted one for db ticks
            for (int b = 0; b < np; b++) begin
                if (m_s2[i][b] == m_flt[i][b]) m_run[i][b] = 0;
                else if (m_run[i][b] + 1 >= db) begin
                    m_flt[i][b] = m_s2[i][b];
                    m_run[i][b] = 0;
                end else m_run[i][b] = m_run[i][b] + 1;
            end
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = pins & mask;
        if (db == 0) m_flt[i] = m_s2[i];
        if (bus_write) begin
            if (bus_address_in == base)              m_dir[i]  = d;
            else if (bus_address_in == base + 24'd1) m_data[i] = d;
            else if (bus_address_in == base + 24'd2) m_en[i]   = d;
            else if (bus_address_in == base + 24'd3) m_edge[i] = d;
        end
    endtask

    function automatic logic [7:0] exp_rd(input int i, input logic [23:0] base);
        logic [7:0] r;
        r = 8'h00;
        if (bus_read) begin
            case (bus_address_in - base)
                24'd0: r = m_dir[i];
                24'd1: r = (m_data[i] & m_dir[i]) | (m_flt[i] & ~m_dir[i]);
                24'd2: r = m_en[i];
                24'd3: r = m_edge[i];
                24'd4: r = m_pend[i];
                default: r = 8'h00;
            endcase
        end
        return r;
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                model_reset(0, 8);
                model_reset(1, 3);
            end else if (clk_ce) begin
                model_step(0, pin_in0, 8, 0, BASE0);
                model_step(1, {5'b0, pin_in1}, 3, 4, BASE1);
            end
            #1;
            chk("cyc_oe0", pin_oe0, m_dir[0]);
            chk("cyc_out0", pin_out0, m_data[0] & m_dir[0]);
            chk("cyc_irq0", {7'b0, irq0}, {7'b0, m_irq[0]});
            chk("cyc_rd0", rd0, exp_rd(0, BASE0));
            chk("cyc_oe1", {5'b0, pin_oe1}, m_dir[1]);
            chk("cyc_out1", {5'b0, pin_out1}, m_data[1] & m_dir[1]);
            chk("cyc_irq1", {7'b0, irq1}, {7'b0, m_irq[1]});
            chk("cyc_rd1", rd1, exp_rd(1, BASE1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wr(input logic [23:0] addr, input logic [7:0] data);
        bus_write = 1'b1;
        bus_address_in = addr;
        bus_data_in = data;
        @(negedge clk);
        bus_write = 1'b0;
    endtask

    task automatic rd_chk(input int inst, input logic [23:0] addr, input logic [7:0] exp,
                          input string name);
        bus_read = 1'b1;
        bus_address_in = addr;
        #1;
        chk(name, (inst == 0) ? rd0 : rd1, exp);
        bus_read = 1'b0;
    endtask

    logic [7:0] walk[5] = '{8'h3A, 8'h00, 8'hFF, 8'h5A, 8'h3A};

    initial begin
        reset = 1'b1; clk_ce = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = 24'h0; bus_data_in = 8'h00; pin_in0 = 8'hFF; pin_in1 = 3'b111;
        #1 reset = 1'b0;
        #1;
        chk("rst_oe0", pin_oe0, 8'h00);
        chk("rst_out0", pin_out0, 8'h00);
        chk("rst_irq0", {7'b0, irq0}, 8'h00);
        rd_chk(0, BASE0 + 24'd1, 8'hFF, "rst_idle_high");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // direction / data / mixed read
        wr(BASE0, 8'h0F);
        wr(BASE0 + 24'd1, 8'hA5);
        pin_in0 = 8'h3C;
        repeat (3) @(negedge clk);
        chk("oe_0F", pin_oe0, 8'h0F);
        chk("out_05", pin_out0, 8'h05);
        rd_chk(0, BASE0 + 24'd1, 8'h35, "data_rd_35");

        // writes without clk_ce are ignored
        clk_ce = 1'b0;
        wr(BASE0 + 24'd1, 8'h00);
        chk("noce_out", pin_out0, 8'h05);
        clk_ce = 1'b1;
        @(negedge clk);

        // falling-edge interrupt on pin2, latency and W1C
        wr(BASE0 + 24'd2, 8'h04);
        wr(BASE0 + 24'd3, 8'h00);
        pin_in0 = 8'h38;
        @(negedge clk);
        @(negedge clk);
        rd_chk(0, BASE0 + 24'd4, 8'h00, "pend_k1");
        @(negedge clk);
        rd_chk(0, BASE0 + 24'd4, 8'h04, "pend_k2");
        chk("irq_k2", {7'b0, irq0}, 8'h00);
        @(negedge clk);
        chk("irq_k3", {7'b0, irq0}, 8'h01);
        wr(BASE0 + 24'd4, 8'h04);
        rd_chk(0, BASE0 + 24'd4, 8'h00, "pend_w1c");
        @(negedge clk);
        chk("irq_w1c", {7'b0, irq0}, 8'h00);

        // set beats clear in the same tick
        wr(BASE0 + 24'd2, 8'h06);
        wr(BASE0 + 24'd3, 8'h02);
        pin_in0 = 8'h3A;
        @(negedge clk);
        @(negedge clk);
        wr(BASE0 + 24'd4, 8'h02);
        rd_chk(0, BASE0 + 24'd4, 8'h02, "set_over_clr");

        // pin walk with DATA read held, checked by the model
        bus_read = 1'b1;
        bus_address_in = BASE0 + 24'd1;
        foreach (walk[w]) begin
            pin_in0 = walk[w];
            repeat (2) @(negedge clk);
        end
        bus_read = 1'b0;

        // debounce: 3-tick glitch rejected, 4-tick low accepted
        wr(BASE1 + 24'd2, 8'h01);
        wr(BASE1 + 24'd3, 8'h00);
        pin_in1 = 3'b110;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            rd_chk(1, BASE1 + 24'd1, 8'h07, "glitch_filt");
            if (t == 2) pin_in1 = 3'b111;
        end
        rd_chk(1, BASE1 + 24'd4, 8'h00, "glitch_pend");
        pin_in1 = 3'b110;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            rd_chk(1, BASE1 + 24'd1, (t >= 5) ? 8'h06 : 8'h07, "hold_filt");
        end
        rd_chk(1, BASE1 + 24'd4, 8'h01, "hold_pend");

        // asynchronous reset mid-debounce with all pins driven
        wr(BASE0, 8'hFF);
        chk("pre_out", pin_out0, 8'hA5);
        chk("pre_irq0", {7'b0, irq0}, 8'h01);
        chk("pre_irq1", {7'b0, irq1}, 8'h01);
        pin_in1 = 3'b111;
        repeat (3) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_oe0", pin_oe0, 8'h00);
        chk("arst_out0", pin_out0, 8'h00);
        chk("arst_irq0", {7'b0, irq0}, 8'h00);
        chk("arst_irq1", {7'b0, irq1}, 8'h00);
        pin_in0 = 8'h00;
        pin_in1 = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        rd_chk(0, BASE0 + 24'd4, 8'h00, "post_pend0");
        rd_chk(1, BASE1 + 24'd4, 8'h00, "post_pend1");
        chk("post_irq0", {7'b0, irq0}, 8'h00);
        chk("post_irq1", {7'b0, irq1}, 8'h00);

        // narrow port and unmapped addresses
        wr(BASE1, 8'hFF);
        rd_chk(1, BASE1, 8'h07, "narrow_dir");
        chk("narrow_oe", {5'b0, pin_oe1}, 8'h07);
        rd_chk(1, BASE1 + 24'd5, 8'h00, "unmapped1");
        rd_chk(0, BASE0 + 24'd5, 8'h00, "unmapped0");
        rd_chk(0, BASE1, 8'h00, "other_base");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
